// File: rtl/nes_cpu_bus_master_pkg.sv
// Shared timing presets, phase-compare helpers and types for the NES CPU bus master.
package nes_cpu_bus_master_pkg;

  // Default timing, NTSC-like: 12 clk per M2 period, 7 of them high.
  localparam int unsigned M2_DIV_DEFAULT    = 32'd12;
  localparam int unsigned M2_HIGH_DEFAULT   = 32'd7;
  localparam logic [15:0] IDLE_ADDR_DEFAULT = 16'h0000;

  // Console presets.
  localparam int unsigned NTSC_M2_DIV  = 32'd12;
  localparam int unsigned NTSC_M2_HIGH = 32'd7;
  localparam int unsigned PAL_M2_DIV   = 32'd16;
  localparam int unsigned PAL_M2_HIGH  = 32'd10;

  // Phase landmarks for the default timing.
  localparam int unsigned PH_RISE  = M2_DIV_DEFAULT - M2_HIGH_DEFAULT;
  localparam int unsigned PH_LAST  = M2_DIV_DEFAULT - 32'd1;
  localparam int unsigned PH_BOUND = 32'd1;

  // Holding register occupancy.
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

  // One single-beat bus request.
  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
  } bus_req_t;

  // Phase on which M2 goes high for an arbitrary divider.
  function automatic logic [7:0] rise_phase(input int unsigned div, input int unsigned high);
    return 8'(div - high);
  endfunction

  // Final phase of the period for an arbitrary divider.
  function automatic logic [7:0] last_phase(input int unsigned div);
    return 8'(div - 32'd1);
  endfunction

endpackage

// File: rtl/nes_cpu_bus_master_if.sv
// Request/response handshake plus CPU connector signals of the bus master.
interface nes_cpu_bus_master_if;
  import nes_cpu_bus_master_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_rw;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  cpu_data_in;
  logic        irq_n;
  logic        irq;
  logic [31:0] m2_count;

  modport master (
    input  req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
    output req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, irq, m2_count
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_wdata, cpu_data_in, irq_n,
    input  req_ready, rsp_valid, rsp_rdata, m2, romsel, cpu_rw, cpu_addr,
           cpu_data_out, cpu_data_oe, irq, m2_count
  );

endinterface

// File: rtl/nes_m2_phase_gen.sv
// Free-running M2 phase counter; strobes describe what the next clk edge does.
module nes_m2_phase_gen
  import nes_cpu_bus_master_pkg::*;
#(
  parameter int unsigned M2_DIV  = M2_DIV_DEFAULT,
  parameter int unsigned M2_HIGH = M2_HIGH_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic m2_next,
  output logic at_boundary,
  output logic at_last,
  output logic at_rise
);

  localparam logic [7:0] RISE  = rise_phase(M2_DIV, M2_HIGH);
  localparam logic [7:0] LAST  = last_phase(M2_DIV);
  localparam logic [7:0] BOUND = 8'(PH_BOUND);

  logic [7:0] phase;
  logic [7:0] phase_next;

  // Next phase and the edge strobes derived from it.
  always_comb begin
    phase_next = phase + 8'd1;
    at_last    = 1'b0;
    if (phase == LAST) begin
      phase_next = 8'd0;
      at_last    = 1'b1;
    end else begin
      phase_next = phase + 8'd1;
      at_last    = 1'b0;
    end
    m2_next     = (phase_next >= RISE);
    at_rise     = (phase_next == RISE);
    at_boundary = (phase_next == BOUND);
  end

  // Phase counter, 0..M2_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 8'd0;
    end else begin
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/nes_cpu_bus_master.sv
// Turns single-beat requests into 6502-style cartridge bus cycles on a free-running M2.
module nes_cpu_bus_master
  import nes_cpu_bus_master_pkg::*;
#(
  parameter int unsigned M2_DIV    = M2_DIV_DEFAULT,
  parameter int unsigned M2_HIGH   = M2_HIGH_DEFAULT,
  parameter logic [15:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  nes_cpu_bus_master_if.master bus
);

  localparam bus_req_t IDLE_REQ = '{addr: IDLE_ADDR, rw: 1'b1, wdata: 8'h00};

  logic        m2_next, at_boundary, at_last, at_rise;
  hold_state_t hold_state, hold_next;
  logic        load_hold, issue;
  bus_req_t    hold_req, act_req;
  logic        act_idle;
  logic        m2, romsel, data_oe;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        irq_sync, irq;
  logic [31:0] m2_count;

  nes_m2_phase_gen #(.M2_DIV(M2_DIV), .M2_HIGH(M2_HIGH)) u_phase (
    .clk        (clk),
    .reset      (reset),
    .m2_next    (m2_next),
    .at_boundary(at_boundary),
    .at_last    (at_last),
    .at_rise    (at_rise)
  );

  // Holding register occupancy: fill on handshake, drain into the bus at the boundary.
  always_comb begin
    hold_next = hold_state;
    load_hold = 1'b0;
    issue     = 1'b0;
    case (hold_state)
      HOLD_EMPTY: begin
        if (bus.req_valid) begin
          hold_next = HOLD_FULL;
          load_hold = 1'b1;
        end else begin
          hold_next = HOLD_EMPTY;
        end
      end
      HOLD_FULL: begin
        if (at_boundary) begin
          hold_next = HOLD_EMPTY;
          issue     = 1'b1;
        end else begin
          hold_next = HOLD_FULL;
        end
      end
      default: hold_next = HOLD_EMPTY;
    endcase
  end

  // Holding register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_state <= HOLD_EMPTY;
    end else begin
      hold_state <= hold_next;
    end
  end

  // Holding register payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_req <= '0;
    end else if (load_hold) begin
      hold_req <= '{addr: bus.req_addr, rw: bus.req_rw, wdata: bus.req_wdata};
    end
  end

  // Active bus registers change only at the boundary; an empty holding register yields an idle read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_req  <= IDLE_REQ;
      act_idle <= 1'b1;
    end else if (at_boundary) begin
      if (issue) begin
        act_req  <= '{addr: hold_req.addr, rw: hold_req.rw,
                      wdata: (hold_req.rw ? 8'h00 : hold_req.wdata)};
        act_idle <= 1'b0;
      end else begin
        act_req  <= IDLE_REQ;
        act_idle <= 1'b1;
      end
    end
  end

  // M2 and romsel share one flop stage; write drive rises with M2 and holds through phase 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m2      <= 1'b0;
      romsel  <= 1'b1;
      data_oe <= 1'b0;
    end else begin
      m2     <= m2_next;
      romsel <= ~(m2_next & act_req.addr[15]);
      if (at_boundary) begin
        data_oe <= 1'b0;
      end else if (at_rise) begin
        data_oe <= ~act_req.rw;
      end
    end
  end

  // Read data captured on the edge leaving the last phase; response pulses in phase 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      rsp_valid <= at_last & ~act_idle;
      if (at_last & ~act_idle) begin
        rsp_rdata <= act_req.rw ? bus.cpu_data_in : 8'h00;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous cartridge IRQ, inverted to active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync <= 1'b1;
      irq      <= 1'b0;
    end else begin
      irq_sync <= bus.irq_n;
      irq      <= ~irq_sync;
    end
  end

  // Count of M2 rising edges, idle cycles included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m2_count <= 32'd0;
    end else if (at_rise) begin
      m2_count <= m2_count + 32'd1;
    end
  end

  assign bus.req_ready    = (hold_state == HOLD_EMPTY);
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_rdata    = rsp_rdata;
  assign bus.m2           = m2;
  assign bus.romsel       = romsel;
  assign bus.cpu_rw       = act_req.rw;
  assign bus.cpu_addr     = act_req.addr[14:0];
  assign bus.cpu_data_out = act_req.wdata;
  assign bus.cpu_data_oe  = data_oe;
  assign bus.irq          = irq;
  assign bus.m2_count     = m2_count;

endmodule

// File: tb/tb_nes_cpu_bus_master.sv
// Randomized and directed bench for nes_cpu_bus_master against a period-level reference model.
module tb_nes_cpu_bus_master;
  import nes_cpu_bus_master_pkg::*;

  localparam int DIV  = int'(NTSC_M2_DIV);
  localparam int HIGH = int'(NTSC_M2_HIGH);
  localparam int RISE = DIV - HIGH;
  localparam logic [15:0] IDLE = 16'h0000;

  logic clk;
  logic reset;

  nes_cpu_bus_master_if bus();

  nes_cpu_bus_master #(.M2_DIV(DIV), .M2_HIGH(HIGH), .IDLE_ADDR(IDLE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: t = clk edges since reset release; phase after t edges is t % DIV.
  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic        idle;
  } mtx_t;

  mtx_t       q[$];
  mtx_t       cur;
  int         t;
  logic [7:0] m_rdata;
  logic       m_s;
  logic       m_irq;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    q.delete();
    cur = '{addr: IDLE, rw: 1'b1, wdata: 8'h00, idle: 1'b1};
    m_rdata = 8'h00;
    m_s = 1'b1;
    m_irq = 1'b0;
  endtask

  task automatic model_edge();
    int   ph;
    bit   hs;
    mtx_t nx;
    ph = t % DIV;
    hs = bus.req_valid && (q.size() == 0);
    nx = '{addr: bus.req_addr, rw: bus.req_rw, wdata: bus.req_wdata, idle: 1'b0};
    if (ph == DIV - 1 && !cur.idle) m_rdata = cur.rw ? bus.cpu_data_in : 8'h00;
    if (ph == 0) begin
      if (q.size() != 0) cur = q.pop_front();
      else cur = '{addr: IDLE, rw: 1'b1, wdata: 8'h00, idle: 1'b1};
    end
    if (hs) q.push_back(nx);
    m_irq = !m_s;
    m_s = bus.irq_n;
    t++;
  endtask

  task automatic compare_all();
    int          ph;
    bit          em2, eoe, ers;
    logic [31:0] ecnt;
    ph   = t % DIV;
    em2  = (ph >= RISE);
    eoe  = !cur.rw && (em2 || ph == 0);
    ers  = (ph == 0) && !cur.idle;
    ecnt = (t >= RISE) ? 32'((t - RISE) / DIV + 1) : 32'd0;
    check("m2", 32'(bus.m2), 32'(em2));
    check("romsel", 32'(bus.romsel), 32'(!(em2 && cur.addr[15])));
    check("cpu_rw", 32'(bus.cpu_rw), 32'(cur.rw));
    check("cpu_addr", 32'(bus.cpu_addr), 32'(cur.addr[14:0]));
    check("cpu_data_oe", 32'(bus.cpu_data_oe), 32'(eoe));
    if (eoe) check("cpu_data_out", 32'(bus.cpu_data_out), 32'(cur.wdata));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(ers));
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
    check("req_ready", 32'(bus.req_ready), 32'(q.size() == 0));
    check("m2_count", bus.m2_count, ecnt);
    check("irq", 32'(bus.irq), 32'(m_irq));
  endtask

  // Model advances on every active edge outside reset.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) model_edge();
    end
  end

  // Every-cycle comparison on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cmp_en) compare_all();
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while ((t % DIV) != p && n < 2 * DIV) begin
      step();
      n++;
    end
    check("wait_phase_timeout", 32'(t % DIV), 32'(p));
  endtask

  task automatic run_txn(input logic [15:0] addr, input logic rw, input logic [7:0] wdata,
                         input logic [7:0] din, output int romsel_low, output int rw_low,
                         output int oe_high, output int dout_bad, output int rsp_cnt,
                         output logic [7:0] rdata);
    romsel_low = 0; rw_low = 0; oe_high = 0; dout_bad = 0; rsp_cnt = 0; rdata = 8'hEE;
    wait_phase(1);
    bus.cpu_data_in = din;
    bus.req_addr    = addr;
    bus.req_rw      = rw;
    bus.req_wdata   = wdata;
    bus.req_valid   = 1'b1;
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      @(negedge clk);
      if (!bus.romsel) romsel_low++;
      if (!bus.cpu_rw) rw_low++;
      if (bus.cpu_data_oe) begin
        oe_high++;
        if (bus.cpu_data_out !== wdata) dout_bad++;
      end
      if (bus.rsp_valid) begin
        rsp_cnt++;
        rdata = bus.rsp_rdata;
      end
    end
  endtask

  initial begin : stim
    int          rl, wl, oh, db, rc, n, max_low, run_low, bad_gap, prev_rsp, addr_bad;
    logic [7:0]  rd;
    logic [14:0] first_addr;
    logic [31:0] c0;

    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = 16'h0000; bus.req_rw = 1'b1; bus.req_wdata = 8'h00;
    bus.cpu_data_in = 8'h00; bus.irq_n = 1'b1;
    model_reset();
    repeat (3) step();

    // Reset values.
    check("rst_m2", 32'(bus.m2), 32'd0);
    check("rst_romsel", 32'(bus.romsel), 32'd1);
    check("rst_cpu_rw", 32'(bus.cpu_rw), 32'd1);
    check("rst_cpu_addr", 32'(bus.cpu_addr), 32'(IDLE[14:0]));
    check("rst_oe", 32'(bus.cpu_data_oe), 32'd0);
    check("rst_dout", 32'(bus.cpu_data_out), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_irq", 32'(bus.irq), 32'd0);
    check("rst_m2_count", bus.m2_count, 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Read of $8000 returning A5.
    run_txn(16'h8000, 1'b1, 8'h00, 8'hA5, rl, wl, oh, db, rc, rd);
    check("rd_romsel_low_cycles", 32'(rl), 32'd7);
    check("rd_rw_low_cycles", 32'(wl), 32'd0);
    check("rd_rsp_pulses", 32'(rc), 32'd1);
    check("rd_rdata", 32'(rd), 32'hA5);

    // Write of 3C to $6000.
    run_txn(16'h6000, 1'b0, 8'h3C, 8'hFF, rl, wl, oh, db, rc, rd);
    check("wr_romsel_low_cycles", 32'(rl), 32'd0);
    check("wr_rw_low_cycles", 32'(wl), 32'd12);
    check("wr_oe_cycles", 32'(oh), 32'd8);
    check("wr_dout_bad", 32'(db), 32'd0);
    check("wr_rsp_pulses", 32'(rc), 32'd1);
    check("wr_rdata", 32'(rd), 32'h00);

    // Handshake on the phase 0 -> 1 edge waits one full period.
    wait_phase(0);
    bus.req_addr = 16'h1234; bus.req_rw = 1'b1; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    n = 0; first_addr = 15'h7FFF;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) first_addr = bus.cpu_addr;
      if (bus.rsp_valid) break;
    end
    check("bnd_addr_after_edge", 32'(first_addr), 32'(IDLE[14:0]));
    check("bnd_latency", 32'(n), 32'd24);

    // Back-to-back with req_valid held high.
    wait_phase(3);
    bus.req_valid = 1'b1; bus.req_rw = 1'b1;
    rc = 0; max_low = 0; run_low = 0; bad_gap = 0; prev_rsp = -1;
    for (int i = 1; i <= 8 * DIV; i++) begin
      bus.req_addr = 16'($urandom);
      @(negedge clk);
      if (!bus.req_ready) run_low++;
      else run_low = 0;
      if (run_low > max_low) max_low = run_low;
      if (bus.rsp_valid) begin
        if (prev_rsp >= 0 && i - prev_rsp != DIV) bad_gap++;
        prev_rsp = i;
        rc++;
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_beats", 32'(rc), 32'd7);
    check("b2b_bad_spacing", 32'(bad_gap), 32'd0);
    check("b2b_ready_low_le_period", 32'(max_low <= DIV), 32'd1);

    // Ten idle periods.
    repeat (3 * DIV) @(negedge clk);
    c0 = bus.m2_count; rc = 0; addr_bad = 0;
    for (int i = 0; i < 10 * DIV; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) rc++;
      if (bus.cpu_addr !== IDLE[14:0]) addr_bad++;
    end
    check("idle_m2_count_delta", bus.m2_count - c0, 32'd10);
    check("idle_rsp", 32'(rc), 32'd0);
    check("idle_addr_bad", 32'(addr_bad), 32'd0);

    // Reset at phase 8 during a write.
    wait_phase(1);
    bus.req_addr = 16'h6000; bus.req_rw = 1'b0; bus.req_wdata = 8'h55; bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (!((t % DIV) == 8 && !cur.idle) && n < 3 * DIV) begin
      step();
      n++;
    end
    check("mid_pre_oe", 32'(bus.cpu_data_oe), 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check("mid_oe", 32'(bus.cpu_data_oe), 32'd0);
    check("mid_m2", 32'(bus.m2), 32'd0);
    check("mid_romsel", 32'(bus.romsel), 32'd1);
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    rc = 0;
    repeat (2 * DIV) begin
      @(negedge clk);
      if (bus.rsp_valid) rc++;
    end
    check("mid_no_rsp", 32'(rc), 32'd0);
    run_txn(16'h8000, 1'b1, 8'h00, 8'h5A, rl, wl, oh, db, rc, rd);
    check("post_rst_rsp", 32'(rc), 32'd1);
    check("post_rst_rdata", 32'(rd), 32'h5A);

    // IRQ synchronizer latency.
    step();
    bus.irq_n = 1'b0;
    step();
    @(negedge clk);
    check("irq_after_1clk", 32'(bus.irq), 32'd0);
    @(negedge clk);
    check("irq_after_2clk", 32'(bus.irq), 32'd1);
    bus.irq_n = 1'b1;
    @(negedge clk);
    check("irq_rel_after_1clk", 32'(bus.irq), 32'd1);
    @(negedge clk);
    check("irq_rel_after_2clk", 32'(bus.irq), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step();
      bus.req_valid   = ($urandom_range(0, 2) != 0);
      bus.req_addr    = 16'($urandom);
      bus.req_rw      = 1'($urandom_range(0, 1));
      bus.req_wdata   = 8'($urandom);
      bus.cpu_data_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) bus.irq_n = ~bus.irq_n;
    end
    bus.req_valid = 1'b0;
    repeat (3 * DIV) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
